// File: rtl/scarv_soc_pkg.sv
// Shared scarv_soc definitions: bus/strobe widths and the BRAM port tracker encodings.
package scarv_soc_pkg;

   localparam int BUS_W  = 32;
   localparam int STRB_W = 4;

   localparam logic [1:0] TRK_IDLE = 2'd0;
   localparam logic [1:0] TRK_WAIT = 2'd1;
   localparam logic [1:0] TRK_HOLD = 2'd2;

endpackage

// File: rtl/scarv_soc_bram_arb_port.sv
// Per-requester response tracker: one outstanding access, BRAM data shown live in WAIT,
// held in a private register (HOLD) while the requester stalls.
module scarv_soc_bram_arb_port
   import scarv_soc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_req,
   input  logic             i_gnt,
   input  logic             i_err,
   input  logic             i_rsp_ready,
   input  logic [BUS_W-1:0] i_bram_rdata,
   output logic             o_elig,
   output logic             o_rsp_valid,
   output logic             o_rsp_err,
   output logic [BUS_W-1:0] o_rdata
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [BUS_W-1:0] r_hold;
   logic             r_err;
   logic             w_busy;

   assign w_busy      = (r_state != TRK_IDLE);
   assign o_rsp_valid = !rst && w_busy;
   assign o_rsp_err   = o_rsp_valid && r_err;
   // A busy port may re-request in the same cycle its response is taken.
   assign o_elig      = !rst && i_req && (!w_busy || i_rsp_ready);

   always_comb begin
      o_rdata = '0;
      if (o_rsp_valid)
         o_rdata = (r_state == TRK_HOLD) ? r_hold : i_bram_rdata;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TRK_IDLE: if (i_gnt) w_state_nxt = TRK_WAIT;
         TRK_WAIT,
         TRK_HOLD: begin
            if (i_rsp_ready)
               w_state_nxt = i_gnt ? TRK_WAIT : TRK_IDLE;
            else
               w_state_nxt = TRK_HOLD;
         end
         default:  w_state_nxt = TRK_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TRK_IDLE;
         r_hold  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // BRAM output is only valid for one cycle; capture it before the other port reuses the BRAM.
         if (r_state == TRK_WAIT && !i_rsp_ready)
            r_hold <= i_bram_rdata;
         if (i_gnt)
            r_err <= i_err;
      end
   end

endmodule

// File: rtl/scarv_soc_bram_arb.sv
// Two-port round-robin arbiter in front of a single-port BRAM (1-cycle read latency).
module scarv_soc_bram_arb
   import scarv_soc_pkg::*;
#(
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned WRITE_EN = 1,
   localparam int         LW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req,
   output logic              p0_gnt,
   input  logic              p0_wen,
   input  logic [STRB_W-1:0] p0_strb,
   input  logic [LW-1:0]     p0_addr,
   input  logic [BUS_W-1:0]  p0_wdata,
   output logic              p0_rsp_valid,
   input  logic              p0_rsp_ready,
   output logic [BUS_W-1:0]  p0_rdata,
   output logic              p0_rsp_err,

   input  logic              p1_req,
   output logic              p1_gnt,
   input  logic              p1_wen,
   input  logic [STRB_W-1:0] p1_strb,
   input  logic [LW-1:0]     p1_addr,
   input  logic [BUS_W-1:0]  p1_wdata,
   output logic              p1_rsp_valid,
   input  logic              p1_rsp_ready,
   output logic [BUS_W-1:0]  p1_rdata,
   output logic              p1_rsp_err,

   output logic              bram_en,
   output logic [STRB_W-1:0] bram_we,
   output logic [LW-1:0]     bram_addr,
   output logic [BUS_W-1:0]  bram_wdata,
   input  logic [BUS_W-1:0]  bram_rdata
);

   localparam logic WR_OK = (WRITE_EN != 0);

   logic r_ptr;
   logic w_elig0;
   logic w_elig1;

   // Pointer names the winner on contention; it then flips to the loser.
   assign p0_gnt = w_elig0 && (!w_elig1 || !r_ptr);
   assign p1_gnt = w_elig1 && (!w_elig0 ||  r_ptr);

   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= 1'b0;
      else if (w_elig0 && w_elig1)
         r_ptr <= ~r_ptr;
   end

   always_comb begin
      bram_en    = 1'b0;
      bram_we    = '0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (p0_gnt) begin
         bram_en    = 1'b1;
         bram_we    = (p0_wen && WR_OK) ? p0_strb : '0;
         bram_addr  = p0_addr;
         bram_wdata = p0_wdata;
      end else if (p1_gnt) begin
         bram_en    = 1'b1;
         bram_we    = (p1_wen && WR_OK) ? p1_strb : '0;
         bram_addr  = p1_addr;
         bram_wdata = p1_wdata;
      end
   end

   scarv_soc_bram_arb_port u_port0 (
      .clk          (clk),
      .rst          (rst),
      .i_req        (p0_req),
      .i_gnt        (p0_gnt),
      .i_err        (p0_wen && !WR_OK),
      .i_rsp_ready  (p0_rsp_ready),
      .i_bram_rdata (bram_rdata),
      .o_elig       (w_elig0),
      .o_rsp_valid  (p0_rsp_valid),
      .o_rsp_err    (p0_rsp_err),
      .o_rdata      (p0_rdata)
   );

   scarv_soc_bram_arb_port u_port1 (
      .clk          (clk),
      .rst          (rst),
      .i_req        (p1_req),
      .i_gnt        (p1_gnt),
      .i_err        (p1_wen && !WR_OK),
      .i_rsp_ready  (p1_rsp_ready),
      .i_bram_rdata (bram_rdata),
      .o_elig       (w_elig1),
      .o_rsp_valid  (p1_rsp_valid),
      .o_rsp_err    (p1_rsp_err),
      .o_rdata      (p1_rdata)
   );

endmodule

// File: tb/tb_scarv_soc_bram_arb.sv
// Bench for scarv_soc_bram_arb: a writable and a ROM instance share stimulus; each has its own BRAM model.
module tb_scarv_soc_bram_arb;

   localparam int DEPTH = 1024;
   localparam int LW    = 10;
   localparam int NW    = DEPTH / 4;

   logic clk = 1'b0;
   logic rst;
   logic load;

   logic        req   [2];
   logic        wen   [2];
   logic        rdy   [2];
   logic [3:0]  strb  [2];
   logic [LW-1:0] addr [2];
   logic [31:0] wdata [2];

   logic        gnt   [2][2];
   logic        rv    [2][2];
   logic        er    [2][2];
   logic [31:0] rdata [2][2];

   logic          ben    [2];
   logic [3:0]    bwe    [2];
   logic [LW-1:0] baddr  [2];
   logic [31:0]   bwdata [2];
   logic [31:0]   brdata [2];

   logic [31:0] mem      [2][NW];
   logic [31:0] init_mem [NW];

   // Reference model: per instance, per port: pending response value captured at grant time.
   bit          m_out  [2][2];
   bit          m_err  [2][2];
   logic [31:0] m_data [2][2];
   bit          m_ptr  [2];
   bit          m_any  [2];
   bit          m_both [2];
   int          m_win  [2];
   logic [31:0] ref_mem [2][NW];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar d = 0; d < 2; d++) begin : g_dut
      scarv_soc_bram_arb #(.DEPTH(DEPTH), .WRITE_EN((d == 0) ? 1 : 0)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .p0_req       (req[0]),
         .p0_gnt       (gnt[d][0]),
         .p0_wen       (wen[0]),
         .p0_strb      (strb[0]),
         .p0_addr      (addr[0]),
         .p0_wdata     (wdata[0]),
         .p0_rsp_valid (rv[d][0]),
         .p0_rsp_ready (rdy[0]),
         .p0_rdata     (rdata[d][0]),
         .p0_rsp_err   (er[d][0]),
         .p1_req       (req[1]),
         .p1_gnt       (gnt[d][1]),
         .p1_wen       (wen[1]),
         .p1_strb      (strb[1]),
         .p1_addr      (addr[1]),
         .p1_wdata     (wdata[1]),
         .p1_rsp_valid (rv[d][1]),
         .p1_rsp_ready (rdy[1]),
         .p1_rdata     (rdata[d][1]),
         .p1_rsp_err   (er[d][1]),
         .bram_en      (ben[d]),
         .bram_we      (bwe[d]),
         .bram_addr    (baddr[d]),
         .bram_wdata   (bwdata[d]),
         .bram_rdata   (brdata[d])
      );
   end

   // Read-first BRAM models, one per instance.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (load) begin
            brdata[d] <= '0;
            for (int i = 0; i < NW; i++) mem[d][i] <= init_mem[i];
         end else if (ben[d]) begin
            brdata[d] <= mem[d][baddr[d][LW-1:2]];
            for (int b = 0; b < 4; b++)
               if (bwe[d][b]) mem[d][baddr[d][LW-1:2]][8*b +: 8] <= bwdata[d][8*b +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Compare every output of both instances against the model for the current inputs.
   task automatic sample();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         bit e [2];
         bit v;
         for (int p = 0; p < 2; p++) e[p] = !rst && req[p] && (!m_out[d][p] || rdy[p]);
         m_both[d] = e[0] && e[1];
         m_any[d]  = e[0] || e[1];
         if (m_both[d]) m_win[d] = m_ptr[d] ? 1 : 0;
         else           m_win[d] = e[1] ? 1 : 0;
         for (int p = 0; p < 2; p++) begin
            v = !rst && m_out[d][p];
            check($sformatf("d%0d p%0d gnt", d, p), gnt[d][p], m_any[d] && (m_win[d] == p));
            check($sformatf("d%0d p%0d rsp_valid", d, p), rv[d][p], v);
            check($sformatf("d%0d p%0d rdata", d, p), rdata[d][p], v ? m_data[d][p] : 32'h0);
            check($sformatf("d%0d p%0d rsp_err", d, p), er[d][p], v && m_err[d][p]);
         end
         check($sformatf("d%0d bram_en", d), ben[d], m_any[d]);
         check($sformatf("d%0d bram_we", d), bwe[d],
               (m_any[d] && d == 0 && wen[m_win[d]]) ? strb[m_win[d]] : 4'h0);
         if (m_any[d]) begin
            check($sformatf("d%0d bram_addr", d), baddr[d], addr[m_win[d]]);
            check($sformatf("d%0d bram_wdata", d), bwdata[d], wdata[m_win[d]]);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_out[d][0] = 0;
            m_out[d][1] = 0;
            m_ptr[d]    = 0;
         end else begin
            for (int p = 0; p < 2; p++)
               if (m_out[d][p] && rdy[p]) m_out[d][p] = 0;
            if (m_any[d]) begin
               int w;
               w = m_win[d];
               m_out[d][w]  = 1;
               m_data[d][w] = ref_mem[d][addr[w][LW-1:2]];
               m_err[d][w]  = wen[w] && (d == 1);
               if (wen[w] && d == 0)
                  for (int b = 0; b < 4; b++)
                     if (strb[w][b]) ref_mem[d][addr[w][LW-1:2]][8*b +: 8] = wdata[w][8*b +: 8];
            end
            if (m_both[d]) m_ptr[d] = !m_ptr[d];
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         req[p] = 0; wen[p] = 0; rdy[p] = 1; strb[p] = '0; addr[p] = '0; wdata[p] = '0;
      end
   endtask

   task automatic set_req(input int p, input bit w, input logic [3:0] s,
                          input logic [LW-1:0] a, input logic [31:0] dat);
      req[p] = 1; wen[p] = w; strb[p] = s; addr[p] = a; wdata[p] = dat;
   endtask

   initial begin
      for (int i = 0; i < NW; i++) init_mem[i] = $urandom;
      init_mem[0]  = 32'h11223344;
      init_mem[4]  = 32'hDEADBEEF;
      init_mem[8]  = 32'h12345678;
      init_mem[16] = 32'h11223344;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NW; i++) ref_mem[d][i] = init_mem[i];
         m_ptr[d] = 0;
         for (int p = 0; p < 2; p++) begin
            m_out[d][p] = 0; m_err[d][p] = 0; m_data[d][p] = '0;
         end
      end
      idle_inputs();
      rst  = 1;
      load = 1;
      repeat (2) @(posedge clk);
      #1 load = 0;

      // Reset holds grants off even with requests present
      req[0] = 1; req[1] = 1;
      sample();
      check("rst gnt0", gnt[0][0], 0);
      check("rst gnt1", gnt[0][1], 0);
      check("rst bram_en", ben[0], 0);
      advance();
      rst = 0; idle_inputs();
      sample();
      check("post-rst rsp_valid", rv[0][0], 0);
      advance();

      // Scenario 1: single read, 1-cycle latency
      set_req(0, 0, 4'h0, 10'h010, 32'h0);
      sample(); check("s1 gnt", gnt[0][0], 1);
      advance(); idle_inputs();
      sample(); check("s1 valid", rv[0][0], 1); check("s1 rdata", rdata[0][0], 32'hDEADBEEF);
      advance();

      // Scenario 2: both request continuously -> alternating grants
      for (int i = 0; i < 6; i++) begin
         set_req(0, 0, 4'h0, LW'($urandom_range(0, NW-1) * 4), 32'h0);
         set_req(1, 0, 4'h0, LW'($urandom_range(0, NW-1) * 4), 32'h0);
         sample();
         check($sformatf("s2 gnt0 #%0d", i), gnt[0][0], (i % 2) == 0);
         check($sformatf("s2 gnt1 #%0d", i), gnt[0][1], (i % 2) == 1);
         check($sformatf("s2 bram_en #%0d", i), ben[0], 1);
         advance();
      end
      idle_inputs(); sample(); advance();

      // Scenario 3: p1 stalls its response while p0 keeps the BRAM busy
      set_req(1, 0, 4'h0, 10'h020, 32'h0);
      sample(); check("s3 gnt1", gnt[0][1], 1);
      advance();
      for (int i = 0; i < 3; i++) begin
         rdy[1] = 0;
         set_req(0, 0, 4'h0, LW'($urandom_range(0, NW-1) * 4), 32'h0);
         sample();
         check($sformatf("s3 hold valid #%0d", i), rv[0][1], 1);
         check($sformatf("s3 hold rdata #%0d", i), rdata[0][1], 32'h12345678);
         check($sformatf("s3 no regrant #%0d", i), gnt[0][1], 0);
         check($sformatf("s3 p0 gnt #%0d", i), gnt[0][0], 1);
         advance();
      end
      idle_inputs();
      sample(); check("s3 accept rdata", rdata[0][1], 32'h12345678);
      advance(); sample(); advance();

      // Scenario 4: ROM instance rejects writes with an error response
      set_req(0, 1, 4'hF, 10'h000, 32'hA5A5A5A5);
      sample();
      check("s4 rom bram_en", ben[1], 1);
      check("s4 rom bram_we", bwe[1], 4'h0);
      check("s4 ram bram_we", bwe[0], 4'hF);
      advance();
      set_req(0, 0, 4'h0, 10'h000, 32'h0);
      sample();
      check("s4 rom err", er[1][0], 1);
      check("s4 ram err", er[0][0], 0);
      advance(); idle_inputs();
      sample();
      check("s4 rom readback", rdata[1][0], 32'h11223344);
      check("s4 rom read err", er[1][0], 0);
      check("s4 ram readback", rdata[0][0], 32'hA5A5A5A5);
      advance();

      // Scenario 5: partial-strobe write then read back
      set_req(0, 1, 4'h3, 10'h040, 32'hFFFF0000);
      sample(); advance();
      set_req(0, 0, 4'h0, 10'h040, 32'h0);
      sample(); advance(); idle_inputs();
      sample(); check("s5 merged word", rdata[0][0], 32'h11220000);
      advance();

      // Scenario 6: reset while p0 is waiting; pointer returns to p0
      set_req(0, 0, 4'h0, 10'h010, 32'h0);
      set_req(1, 0, 4'h0, 10'h020, 32'h0);
      sample(); check("s6 first gnt0", gnt[0][0], 1);
      advance();
      rst = 1;
      sample();
      check("s6 rst valid", rv[0][0], 0);
      check("s6 rst gnt1", gnt[0][1], 0);
      check("s6 rst bram_en", ben[0], 0);
      advance();
      rst = 0; idle_inputs();
      sample();
      check("s6 dropped p0", rv[0][0], 0);
      check("s6 dropped p1", rv[0][1], 0);
      advance();
      set_req(0, 0, 4'h0, 10'h010, 32'h0);
      set_req(1, 0, 4'h0, 10'h020, 32'h0);
      sample();
      check("s6 ptr reset gnt0", gnt[0][0], 1);
      check("s6 ptr reset gnt1", gnt[0][1], 0);
      advance(); idle_inputs(); sample(); advance();

      // Randomised traffic over a small address window to force conflicts and stalls
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int p = 0; p < 2; p++) begin
            req[p]   = ($urandom_range(0, 3) != 0);
            wen[p]   = $urandom_range(0, 1) == 1;
            strb[p]  = 4'($urandom);
            addr[p]  = LW'(($urandom_range(0, 7) << 2) | ($urandom & 3));
            wdata[p] = $urandom;
            rdy[p]   = ($urandom_range(0, 3) != 0);
         end
         sample();
         advance();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
